// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from the timing generator to the image source.
// Master drives sync, strobe, coordinates and frame bookkeeping.
interface video_timing_gen_if;
  logic        img_hsync;
  logic        img_vsync;
  logic        img_de;
  logic [11:0] x_axis;
  logic [11:0] y_axis;
  logic        frame_start;
  logic        line_end;
  logic [15:0] frame_cnt;

  modport master (
    output img_hsync, img_vsync, img_de,
    output x_axis, y_axis,
    output frame_start, line_end, frame_cnt
  );

  modport slave (
    input img_hsync, img_vsync, img_de,
    input x_axis, y_axis,
    input frame_start, line_end, frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running progressive raster generator with programmable porches.
// Outputs are registered decodes of the h/v counters, one clock behind.
module video_timing_gen #(
  parameter int H_DISP   = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_POL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [11:0] H_END = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_SYN = 12'(H_SYNC);
  localparam logic [11:0] H_BEG = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_FIN = 12'(H_SYNC + H_BACK + H_DISP - 1);

  localparam logic [11:0] V_END = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_SYN = 12'(V_SYNC);
  localparam logic [11:0] V_BEG = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_FIN = 12'(V_SYNC + V_BACK + V_DISP - 1);

  localparam logic ACT = (SYNC_POL != 0);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;
  logic        h_wrap;
  logic        v_wrap;
  logic        h_act;
  logic        v_act;
  logic        de_n;
  logic        fs_n;
  logic        le_n;
  logic        last_n;

  always_comb begin
    h_wrap = (h_cnt == H_END);
    v_wrap = (v_cnt == V_END);
    h_nxt  = h_wrap ? 12'd0 : h_cnt + 12'd1;
    v_nxt  = v_cnt;
    if (h_wrap)
      v_nxt = v_wrap ? 12'd0 : v_cnt + 12'd1;
    h_act  = (h_cnt >= H_BEG) && (h_cnt <= H_FIN);
    v_act  = (v_cnt >= V_BEG) && (v_cnt <= V_FIN);
    de_n   = h_act && v_act;
    fs_n   = (h_cnt == H_BEG) && (v_cnt == V_BEG);
    le_n   = de_n && (h_cnt == H_FIN);
    last_n = le_n && (v_cnt == V_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      vid.img_hsync   <= ~ACT;
      vid.img_vsync   <= ~ACT;
      vid.img_de      <= 1'b0;
      vid.x_axis      <= '0;
      vid.y_axis      <= '0;
      vid.frame_start <= 1'b0;
      vid.line_end    <= 1'b0;
      vid.frame_cnt   <= '0;
    end else if (en) begin
      h_cnt           <= h_nxt;
      v_cnt           <= v_nxt;
      vid.img_hsync   <= (h_cnt < H_SYN) ? ACT : ~ACT;
      vid.img_vsync   <= (v_cnt < V_SYN) ? ACT : ~ACT;
      vid.img_de      <= de_n;
      vid.x_axis      <= de_n ? h_cnt - H_BEG : 12'd0;
      vid.y_axis      <= de_n ? v_cnt - V_BEG : 12'd0;
      vid.frame_start <= fs_n;
      vid.line_end    <= le_n;
      if (last_n)
        vid.frame_cnt <= vid.frame_cnt + 16'd1;
    end else begin
      // stalled: hold position, but never repeat a pixel strobe
      vid.img_de      <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.line_end    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 raster and a tiny 7x6 raster.
// Expected values are hand-derived from the porch parameters.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst0_n, en0, rst1_n, en1;
  int   ntot = 0;
  int   nbad = 0;

  video_timing_gen_if bus0 ();
  video_timing_gen_if bus1 ();

  video_timing_gen dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .en    (en0),
    .vid   (bus0)
  );

  video_timing_gen #(
    .H_DISP(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISP(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .en    (en1),
    .vid   (bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rst0(input string tag);
    chk({tag, "_hs"}, 32'(bus0.img_hsync), 1);
    chk({tag, "_vs"}, 32'(bus0.img_vsync), 1);
    chk({tag, "_de"}, 32'(bus0.img_de), 0);
    chk({tag, "_x"}, 32'(bus0.x_axis), 0);
    chk({tag, "_y"}, 32'(bus0.y_axis), 0);
    chk({tag, "_fs"}, 32'(bus0.frame_start), 0);
    chk({tag, "_le"}, 32'(bus0.line_end), 0);
    chk({tag, "_fc"}, 32'(bus0.frame_cnt), 0);
  endtask

  // Steps dut0 until its first de; c = output cycle after first enable.
  task automatic run_to_de(output int c, output int hs, output int vs);
    c  = 0;
    hs = 0;
    vs = 0;
    while (c < 30000) begin
      tick();
      c++;
      if (c <= 800 && bus0.img_hsync == 1'b0) hs++;
      if (c <= 1700 && bus0.img_vsync == 1'b0) vs++;
      if (bus0.img_de) break;
    end
  endtask

  initial begin
    int c, hs, vs, n, k;
    logic [11:0] px;
    rst0_n = 1'b0; en0 = 1'b0;
    rst1_n = 1'b0; en1 = 1'b0;
    tick(); tick();

    chk_rst0("rst0");
    chk("rst1_hs", 32'(bus1.img_hsync), 0);
    chk("rst1_vs", 32'(bus1.img_vsync), 0);
    chk("rst1_de", 32'(bus1.img_de), 0);

    // released but stalled: nothing moves
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    tick(); tick(); tick();
    chk("stall0_hs", 32'(bus0.img_hsync), 1);
    chk("stall1_hs", 32'(bus1.img_hsync), 0);

    // ---- tiny raster, active-high syncs ----
    en1 = 1'b1;
    tick();
    chk("t_hs1", 32'(bus1.img_hsync), 1);
    chk("t_vs1", 32'(bus1.img_vsync), 1);
    c = 1;
    while (c < 100 && !bus1.img_de) begin
      tick();
      c++;
    end
    chk("t_first_de", 32'(c), 17);
    chk("t_fs", 32'(bus1.frame_start), 1);
    hs = 0; vs = 0; n = 0;
    for (int i = 0; i < 42; i++) begin
      if (i > 0) tick();
      if (bus1.img_hsync) hs++;
      if (bus1.img_vsync) vs++;
      if (bus1.img_de) n++;
      if (i < 4) begin
        chk("t_x_seq", 32'(bus1.x_axis), 32'(i));
        chk("t_y0", 32'(bus1.y_axis), 0);
      end
      if (i == 3) chk("t_le0", 32'(bus1.line_end), 1);
      if (i == 16) chk("t_fc_pre", 32'(bus1.frame_cnt), 0);
      if (i == 17) begin
        chk("t_last_x", 32'(bus1.x_axis), 3);
        chk("t_last_y", 32'(bus1.y_axis), 2);
        chk("t_last_le", 32'(bus1.line_end), 1);
        chk("t_fc_inc", 32'(bus1.frame_cnt), 1);
      end
    end
    chk("t_de_cnt", 32'(n), 12);
    chk("t_hs_cnt", 32'(hs), 6);
    chk("t_vs_cnt", 32'(vs), 7);
    tick();
    chk("t_fs2", 32'(bus1.frame_start), 1);

    // stall 7 clks mid-frame: frame grows by 7
    for (int i = 0; i < 5; i++) tick();
    k = 5;
    n = 0;
    en1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      k++;
      if (bus1.img_de || bus1.frame_start) n++;
    end
    chk("t_stall_de", 32'(n), 0);
    en1 = 1'b1;
    while (k < 200) begin
      tick();
      k++;
      if (bus1.frame_start) break;
    end
    chk("t_frame_len", 32'(k), 49);

    // frame counter wrap
    en1 = 1'b0;
    tick();
    force bus1.frame_cnt = 16'hFFFF;
    tick();
    release bus1.frame_cnt;
    tick();
    chk("t_fc_hold", 32'(bus1.frame_cnt), 32'hFFFF);
    en1 = 1'b1;
    k = 0;
    while (k < 100 && bus1.frame_cnt == 16'hFFFF) begin
      tick();
      k++;
    end
    chk("t_fc_wrap", 32'(bus1.frame_cnt), 0);
    en1 = 1'b0;

    // ---- default 640x480 raster ----
    en0 = 1'b1;
    run_to_de(c, hs, vs);
    chk("d_hs_cnt", 32'(hs), 96);
    chk("d_vs_cnt", 32'(vs), 1600);
    chk("d_first_de", 32'(c), 28145);
    chk("d_fs", 32'(bus0.frame_start), 1);
    chk("d_x0", 32'(bus0.x_axis), 0);
    chk("d_y0", 32'(bus0.y_axis), 0);
    for (int i = 0; i < 100; i++) tick();
    chk("d_x100", 32'(bus0.x_axis), 100);
    chk("d_fs_clr", 32'(bus0.frame_start), 0);

    en0 = 1'b0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus0.img_de) n++;
    end
    chk("d_stall_de", 32'(n), 0);
    chk("d_stall_x", 32'(bus0.x_axis), 100);
    en0 = 1'b1;
    tick();
    chk("d_resume_de", 32'(bus0.img_de), 1);
    chk("d_resume_x", 32'(bus0.x_axis), 101);

    // x runs 101..639 without gap or repeat
    px = 12'd101;
    n = 0;
    k = 1;
    while (k < 1000 && !bus0.line_end) begin
      tick();
      k++;
      if (bus0.img_de) begin
        if (bus0.x_axis != px + 12'd1) n++;
        px = bus0.x_axis;
      end
    end
    chk("d_x_gaps", 32'(n), 0);
    chk("d_le_x", 32'(bus0.x_axis), 639);
    chk("d_le_y", 32'(bus0.y_axis), 0);
    chk("d_le_de_run", 32'(k), 539);
    tick();
    chk("d_le_clr", 32'(bus0.line_end), 0);

    // reset mid-frame at row 2
    k = 0;
    while (k < 3000 && !(bus0.img_de && bus0.y_axis == 12'd2)) begin
      tick();
      k++;
    end
    chk("d_row2", 32'(bus0.y_axis), 2);
    rst0_n = 1'b0;
    tick();
    chk_rst0("mid_rst");
    tick();
    rst0_n = 1'b1;
    tick();
    chk("d_rst_hs", 32'(bus0.img_hsync), 0);
    chk("d_rst_vs", 32'(bus0.img_vsync), 0);
    chk("d_rst_de", 32'(bus0.img_de), 0);
    // task above starts counting on the next edge, so this edge is cycle 1
    run_to_de(c, hs, vs);
    chk("d_re_de", 32'(c), 28144);
    chk("d_re_x", 32'(bus0.x_axis), 0);
    chk("d_re_y", 32'(bus0.y_axis), 0);
    chk("d_re_fc", 32'(bus0.frame_cnt), 0);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
